// File: rtl/riscv_pkg.sv
// Shared definitions for the unified-memory core: arbiter FSM states,
// legal byte-enable patterns and the opcodes the core decodes.
package riscv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B3 = 4'b1000;
  localparam logic [3:0] BE_H0 = 4'b0011;
  localparam logic [3:0] BE_H1 = 4'b1100;
  localparam logic [3:0] BE_W  = 4'b1111;

  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] JALR  = 7'b1100111;

endpackage

// File: rtl/riscv_mem_align_chk.sv
// Combinational legality check of a byte address and byte-enable pattern
// against lane alignment and the size of the unified array.
module riscv_mem_align_chk
  import riscv_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic [31:0] addr_i,
  input  logic [3:0]  be_i,
  output logic        err_o
);

  logic misalign;
  logic out_of_range;

  always_comb begin
    misalign = 1'b0;
    unique case (be_i)
      BE_W:         misalign = (addr_i[1:0] != 2'b00);
      BE_H0, BE_H1: misalign = addr_i[0] | (be_i != (addr_i[1] ? BE_H1 : BE_H0));
      BE_B0, BE_B1,
      BE_B2, BE_B3: misalign = (be_i != (4'b0001 << addr_i[1:0]));
      default:      misalign = 1'b1;
    endcase
  end

  // Word index beyond the array depth.
  assign out_of_range = |addr_i[31:ADDR_W+2];

  assign err_o = misalign | out_of_range;

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Round-robin sequencer sharing one single-port byte-writable memory between
// the instruction-fetch port and the load/store port of the core.
module riscv_mem_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter bit RST_LAST_D = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ack,
  output logic              if_err,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic              d_err,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_e              state_q;
  logic                win_d_q;
  logic                err_q;
  logic                store_q;
  logic                last_d_q;
  logic                mem_en_q;
  logic [3:0]          mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         mem_wdata_q;

  logic                if_bad;
  logic                d_bad;
  logic                any_req;
  logic                grant_d;
  logic                grant_err;
  logic [ADDR_W-1:0]   grant_addr;

  riscv_mem_align_chk #(.ADDR_W(ADDR_W)) u_if_chk (
    .addr_i (if_addr),
    .be_i   (BE_W),
    .err_o  (if_bad)
  );

  riscv_mem_align_chk #(.ADDR_W(ADDR_W)) u_d_chk (
    .addr_i (d_addr),
    .be_i   (d_be),
    .err_o  (d_bad)
  );

  // On a tie the requester that was not granted last wins.
  assign any_req    = if_req | d_req;
  assign grant_d    = d_req & (~if_req | ~last_d_q);
  assign grant_err  = grant_d ? d_bad : if_bad;
  assign grant_addr = grant_d ? d_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      win_d_q     <= 1'b0;
      err_q       <= 1'b0;
      store_q     <= 1'b0;
      last_d_q    <= RST_LAST_D;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 4'b0000;
          if (any_req) begin
            win_d_q     <= grant_d;
            last_d_q    <= grant_d;
            err_q       <= grant_err;
            store_q     <= grant_d & d_we;
            mem_addr_q  <= grant_addr;
            mem_wdata_q <= grant_d ? d_wdata : 32'h0;
            if (grant_err) begin
              state_q <= ST_RESP;
            end else begin
              state_q  <= ST_ISSUE;
              mem_en_q <= 1'b1;
              mem_we_q <= (grant_d & d_we) ? d_be : 4'b0000;
            end
          end
        end
        ST_ISSUE: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 4'b0000;
          state_q  <= ST_RESP;
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q  <= ST_IDLE;
          mem_en_q <= 1'b0;
          mem_we_q <= 4'b0000;
        end
      endcase
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Memory read data arrives during RESP, so it is passed through under the ack.
  assign if_ack   = (state_q == ST_RESP) & ~win_d_q;
  assign if_err   = if_ack & err_q;
  assign if_rdata = (if_ack & ~err_q) ? mem_rdata : 32'h0;

  assign d_ack    = (state_q == ST_RESP) & win_d_q;
  assign d_err    = d_ack & err_q;
  assign d_rdata  = (d_ack & ~err_q & ~store_q) ? mem_rdata : 32'h0;

endmodule
